riscv_dmem_resp: RTL

Data-memory responder for the RV12 core: accepts one load/store request at a time from the MEM stage, checks alignment and PMA permission, runs the access on a two-phase (grant/response) data bus, and returns a single-cycle ack/err/misaligned/page_fault response with raw bus data to the write-back stage. It is the memory-system end of the dmem handshake that write-back stalls on. The write-back stage performs byte/half lane extraction and sign extension, so this block returns unshifted bus words.

---
 rtl/riscv_state_pkg.sv | 25 ++
 rtl/riscv_dmem_resp_if.sv | 24 ++
 rtl/riscv_dmem_be.sv | 39 +++
 rtl/riscv_dmem_resp.sv | 135 +++++++++++++
 4 files changed

// File: rtl/riscv_state_pkg.sv
// Shared memory-access types for the RV12 data-memory path.
// Also holds the per-size byte-mask helper.
package riscv_state_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_t;

    // Low-aligned byte mask for an access of the given size (up to 8 lanes).
    function automatic logic [7:0] size_mask(input mem_size_t size);
        logic [7:0] mask;
        case (size)
            BYTE:    mask = 8'h01;
            HALF:    mask = 8'h03;
            WORD:    mask = 8'h0F;
            DWORD:   mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/riscv_dmem_resp_if.sv
// Two-phase (grant/response) data bus between the dmem responder and memory.
interface riscv_dmem_resp_if #(
    parameter int XLEN = 32
);
    logic                req;
    logic [XLEN-1:0]     adr;
    logic                we;
    logic [XLEN/8-1:0]   be;
    logic [XLEN-1:0]     d;
    logic                gnt;
    logic                rvalid;
    logic                err;
    logic [XLEN-1:0]     q;

    modport master (
        output req, adr, we, be, d,
        input  gnt, rvalid, err, q
    );

    modport slave (
        input  req, adr, we, be, d,
        output gnt, rvalid, err, q
    );
endinterface

// File: rtl/riscv_dmem_be.sv
// Alignment check, byte-enable and store-lane shifter for one dmem access.
// Purely combinational; the responder registers the results.
module riscv_dmem_be
    import riscv_state_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   adr,
    input  mem_size_t         size,
    input  logic [XLEN-1:0]   d,
    output logic              misaligned,
    output logic [XLEN-1:0]   adr_aligned,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   d_lane
);
    localparam int BW  = XLEN / 8;
    localparam int LSB = (XLEN == 64) ? 3 : 2;

    logic [LSB-1:0] off_s;
    logic [7:0]     mask_s;

    assign off_s  = adr[LSB-1:0];
    assign mask_s = size_mask(size);

    // Natural alignment per access size, then lane placement within the bus word.
    always_comb begin
        case (size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = adr[0];
            WORD:    misaligned = |adr[1:0];
            DWORD:   misaligned = |adr[2:0];
            default: misaligned = 1'b1;
        endcase
        adr_aligned = {adr[XLEN-1:LSB], {LSB{1'b0}}};
        be          = mask_s[BW-1:0] << off_s;
        d_lane      = d << {off_s, 3'b000};
    end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: checks a MEM-stage request, runs it on the two-phase
// bus and returns a one-cycle ack/err/misaligned/page_fault pulse with raw data.
module riscv_dmem_resp
    import riscv_state_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_i,
    input  logic [XLEN-1:0]   mem_adr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_we_i,
    input  logic [XLEN-1:0]   mem_d_i,
    input  logic              pma_fault_i,
    input  logic              page_fault_i,
    input  logic              flush_i,
    output logic              dmem_ack_o,
    output logic              dmem_err_o,
    output logic              dmem_misaligned_o,
    output logic              dmem_page_fault_o,
    output logic [XLEN-1:0]   dmem_q_o,
    output logic              dmem_busy_o,
    riscv_dmem_resp_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam bit NO_DWORD = (XLEN == 32);

    state_t              state_r;
    logic                kill_r;
    mem_size_t           size_s;
    logic                misaligned_s;
    logic                dword_illegal_s;
    logic [XLEN-1:0]     adr_aligned_s;
    logic [XLEN/8-1:0]   be_s;
    logic [XLEN-1:0]     d_lane_s;

    assign size_s          = mem_size_t'(mem_size_i);
    assign dword_illegal_s = NO_DWORD && (size_s == DWORD);

    riscv_dmem_be #(
        .XLEN (XLEN)
    ) u_be (
        .adr         (mem_adr_i),
        .size        (size_s),
        .d           (mem_d_i),
        .misaligned  (misaligned_s),
        .adr_aligned (adr_aligned_s),
        .be          (be_s),
        .d_lane      (d_lane_s)
    );

    // Access sequencer with registered response, busy and bus address-phase fields.
    // A flush during an access lets the bus cycle finish but swallows its response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r           <= IDLE;
            kill_r            <= 1'b0;
            dmem_ack_o        <= 1'b0;
            dmem_err_o        <= 1'b0;
            dmem_misaligned_o <= 1'b0;
            dmem_page_fault_o <= 1'b0;
            dmem_q_o          <= '0;
            dmem_busy_o       <= 1'b0;
            bus.req           <= 1'b0;
            bus.adr           <= '0;
            bus.we            <= 1'b0;
            bus.be            <= '0;
            bus.d             <= '0;
        end else begin
            dmem_ack_o        <= 1'b0;
            dmem_err_o        <= 1'b0;
            dmem_misaligned_o <= 1'b0;
            dmem_page_fault_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_req_i && !flush_i) begin
                        if (misaligned_s) begin
                            dmem_misaligned_o <= 1'b1;
                        end else if (page_fault_i) begin
                            dmem_page_fault_o <= 1'b1;
                        end else if (pma_fault_i || dword_illegal_s) begin
                            dmem_err_o <= 1'b1;
                        end else begin
                            state_r     <= ADDR;
                            kill_r      <= 1'b0;
                            dmem_busy_o <= 1'b1;
                            bus.req     <= 1'b1;
                            bus.adr     <= adr_aligned_s;
                            bus.we      <= mem_we_i;
                            bus.be      <= be_s;
                            bus.d       <= d_lane_s;
                        end
                    end
                end
                ADDR: begin
                    if (flush_i) begin
                        kill_r <= 1'b1;
                    end
                    if (bus.gnt) begin
                        state_r <= DATA;
                        bus.req <= 1'b0;
                    end
                end
                DATA: begin
                    if (flush_i) begin
                        kill_r <= 1'b1;
                    end
                    if (bus.rvalid) begin
                        state_r     <= IDLE;
                        kill_r      <= 1'b0;
                        dmem_busy_o <= 1'b0;
                        if (!kill_r && !flush_i) begin
                            dmem_ack_o <= ~bus.err;
                            dmem_err_o <= bus.err;
                            dmem_q_o   <= bus.q;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    kill_r      <= 1'b0;
                    dmem_busy_o <= 1'b0;
                    bus.req     <= 1'b0;
                end
            endcase
        end
    end

endmodule
